// File: rtl/out_tile_pkg.sv
// Shared types and constants for the output tile writer.
// Holds the FSM state type, the AXI burst encoding, the default
// geometry and the helpers used to size counters.
package out_tile_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;

  // Default geometry; modules re-derive these from their own parameters.
  localparam int DEF_DW  = 32;
  localparam int DEF_POX = 15;
  localparam int DEF_POY = 3;
  localparam int DEF_OW  = 112;
  localparam int DEF_OH  = 112;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Bits needed for a counter that runs 0..n-1 (never zero width).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int TILES_X = ceil_div(DEF_OW, DEF_POX);
  localparam int TILES_Y = ceil_div(DEF_OH, DEF_POY);
  localparam int BYTES   = DEF_DW / 8;

endpackage

// File: rtl/out_tile_pingpong.sv
// Two-bank ping-pong tile store.
// Ports: clk/rst (sync, active-high); wr_en + wr_tile capture a full
// POY x POX tile into the write bank; release_bank frees the read bank;
// rd_r/rd_c select one element of the read bank onto rd_data.
// accept tells the writer the tile was taken; full/empty reflect the
// bank count; overflow is sticky once a tile arrives with both banks full.
module tile_pingpong
  import out_tile_pkg::*;
#(
  parameter int DW  = 32,
  parameter int POX = 15,
  parameter int POY = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr_en,
  input  logic [POY-1:0][POX-1:0][DW-1:0] wr_tile,
  input  logic                            release_bank,
  input  logic [cnt_w(POY)-1:0]           rd_r,
  input  logic [cnt_w(POX)-1:0]           rd_c,
  output logic [DW-1:0]                   rd_data,
  output logic                            accept,
  output logic                            full,
  output logic                            empty,
  output logic                            overflow
);

  logic [1:0] count;
  logic       wr_ptr;
  logic       rd_ptr;
  logic       do_release;
  logic [POY-1:0][POX-1:0][DW-1:0] bank [2];

  assign full       = (count == 2'd2);
  assign empty      = (count == 2'd0);
  assign accept     = wr_en && !full;
  assign do_release = release_bank && !empty;

  // NOTE: sequential state is assigned with <= so every register in the
  // block sees the pre-edge value of every other one.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (accept)        wr_ptr   <= ~wr_ptr;
      if (do_release)    rd_ptr   <= ~rd_ptr;
      if (wr_en && full) overflow <= 1'b1;
      // A capture and a release in the same cycle cancel out.
      case ({accept, do_release})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the banks are intentionally left out of reset; count says which
  // bank holds live data, so their power-up contents are never read.
  always_ff @(posedge clk) begin
    if (accept) bank[wr_ptr] <= wr_tile;
  end

  assign rd_data = bank[rd_ptr][rd_r][rd_c];

endmodule

// File: rtl/out_tile_writer.sv
// Output tile writer: captures POY x POX result tiles into a ping-pong
// buffer and drains each tile row by row to DRAM, one INCR burst per
// (edge-clipped) row segment, with at most one write outstanding.
// Ports: clk/rst (sync, active-high); result/result_valid tile input;
// init_addr/init_addr_en set the map base and restart tile position;
// AW channel (awaddr/awlen/awburst/awvalid/awready), W channel
// (wdata/wvalid/wready/wlast), B channel (bvalid/bready);
// map_done pulses after the last tile of the map; overflow is sticky.
module out_tile_writer
  import out_tile_pkg::*;
#(
  parameter int DW  = 32,
  parameter int AW  = 32,
  parameter int POX = 15,
  parameter int POY = 3,
  parameter int OW  = 112,
  parameter int OH  = 112
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [POY-1:0][POX-1:0][DW-1:0] result,
  input  logic                            result_valid,
  input  logic [AW-1:0]                   init_addr,
  input  logic                            init_addr_en,
  output logic [AW-1:0]                   awaddr,
  output logic [7:0]                      awlen,
  output logic [1:0]                      awburst,
  output logic                            awvalid,
  input  logic                            awready,
  output logic [DW-1:0]                   wdata,
  output logic                            wvalid,
  input  logic                            wready,
  output logic                            wlast,
  input  logic                            bvalid,
  output logic                            bready,
  output logic                            map_done,
  output logic                            overflow
);

  localparam int TX = ceil_div(OW, POX);
  localparam int TY = ceil_div(OH, POY);
  localparam int NB = DW / 8;
  localparam int XW = cnt_w(TX);
  localparam int YW = cnt_w(TY);
  localparam int RW = cnt_w(POY);
  localparam int CW = cnt_w(POX);

  state_t        state;
  logic [AW-1:0] base;
  logic [XW-1:0] tile_x;
  logic [YW-1:0] tile_y;
  logic [RW-1:0] r;
  logic [CW-1:0] c;

  logic [31:0]   x_left, y_left, cols, rows;
  logic          beat_last, last_row, last_tile, has_next;
  logic [AW-1:0] pix, row_addr;

  logic          accept, full, empty, release_bank;
  logic [DW-1:0] rd_data;

  tile_pingpong #(.DW(DW), .POX(POX), .POY(POY)) u_buf (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (result_valid),
    .wr_tile      (result),
    .release_bank (release_bank),
    .rd_r         (r),
    .rd_c         (c),
    .rd_data      (rd_data),
    .accept       (accept),
    .full         (full),
    .empty        (empty),
    .overflow     (overflow)
  );

  // NOTE: every variable here is assigned on every pass, so no latch is
  // inferred.
  always_comb begin
    // Pixels / rows of the map still uncovered at this tile position.
    x_left = 32'(OW) - 32'(tile_x) * 32'(POX);
    y_left = 32'(OH) - 32'(tile_y) * 32'(POY);
    cols   = (x_left < 32'(POX)) ? x_left : 32'(POX);
    rows   = (y_left < 32'(POY)) ? y_left : 32'(POY);

    beat_last = (32'(c) == cols - 32'd1);
    last_row  = (32'(r) == rows - 32'd1);
    last_tile = (32'(tile_x) == 32'(TX - 1)) && (32'(tile_y) == 32'(TY - 1));

    pix      = (AW'(tile_y) * AW'(POY) + AW'(r)) * AW'(OW) + AW'(tile_x) * AW'(POX);
    row_addr = base + pix * AW'(NB);
  end

  // Bank count after this cycle's release is non-zero iff the other bank
  // was already full or a new tile is captured right now.
  assign has_next     = full || accept;
  assign release_bank = (state == RESP) && bvalid && last_row;

  // Payloads are forced to zero while their valid is low.
  assign awvalid = (state == ADDR);
  assign awaddr  = awvalid ? row_addr : '0;
  assign awlen   = awvalid ? 8'(cols - 32'd1) : 8'd0;
  assign awburst = BURST_INCR;
  assign wvalid  = (state == DATA);
  assign wdata   = wvalid ? rd_data : '0;
  assign wlast   = wvalid && beat_last;
  assign bready  = (state == RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      base     <= '0;
      tile_x   <= '0;
      tile_y   <= '0;
      r        <= '0;
      c        <= '0;
      map_done <= 1'b0;
    end else begin
      map_done <= 1'b0;
      case (state)
        IDLE: begin
          if (init_addr_en && empty) begin
            base   <= init_addr;
            tile_x <= '0;
            tile_y <= '0;
          end
          if (!empty) begin
            r     <= '0;
            state <= ADDR;
          end
        end
        ADDR: begin
          if (awready) begin
            c     <= '0;
            state <= DATA;
          end
        end
        DATA: begin
          if (wready) begin
            c <= c + 1'b1;
            if (beat_last) state <= RESP;
          end
        end
        RESP: begin
          if (bvalid) begin
            if (!last_row) begin
              r     <= r + 1'b1;
              state <= ADDR;
            end else begin
              r <= '0;
              if (last_tile) begin
                map_done <= 1'b1;
                tile_x   <= '0;
                tile_y   <= '0;
                state    <= IDLE;
              end else begin
                if (32'(tile_x) == 32'(TX - 1)) begin
                  tile_x <= '0;
                  tile_y <= tile_y + 1'b1;
                end else begin
                  tile_x <= tile_x + 1'b1;
                end
                state <= has_next ? ADDR : IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_out_tile_writer.sv
// Self-checking bench for out_tile_writer: directed tiles, a table of
// hand-computed tile positions walked during a full-map run, stall,
// overflow and mid-burst reset sequences.
module tb_out_tile_writer;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int POX = 15;
  localparam int POY = 3;
  localparam int OW  = 112;
  localparam int OH  = 112;
  localparam int TX  = 8;
  localparam int TY  = 38;
  localparam logic [AW-1:0] BASE = 32'h1000_0000;

  typedef logic [POY-1:0][POX-1:0][DW-1:0] tile_t;

  typedef struct packed {
    logic [AW-1:0]           addr;
    logic [7:0]              len;
    logic [POX-1:0][DW-1:0]  data;
  } burst_t;

  typedef struct {
    int            idx;
    logic [AW-1:0] addr0;
    logic [7:0]    len;
    int            nbursts;
  } vec_t;

  logic          clk;
  logic          rst;
  tile_t         result;
  logic          result_valid;
  logic [AW-1:0] init_addr;
  logic          init_addr_en;
  logic [AW-1:0] awaddr;
  logic [7:0]    awlen;
  logic [1:0]    awburst;
  logic          awvalid, awready;
  logic [DW-1:0] wdata;
  logic          wvalid, wready, wlast;
  logic          bvalid, bready;
  logic          map_done, overflow;

  out_tile_writer #(.DW(DW), .AW(AW), .POX(POX), .POY(POY), .OW(OW), .OH(OH)) dut (
    .clk          (clk),
    .rst          (rst),
    .result       (result),
    .result_valid (result_valid),
    .init_addr    (init_addr),
    .init_addr_en (init_addr_en),
    .awaddr       (awaddr),
    .awlen        (awlen),
    .awburst      (awburst),
    .awvalid      (awvalid),
    .awready      (awready),
    .wdata        (wdata),
    .wvalid       (wvalid),
    .wready       (wready),
    .wlast        (wlast),
    .bvalid       (bvalid),
    .bready       (bready),
    .map_done     (map_done),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- ready/valid driver ----------------
  int stall_mode = 0;   // 0: always ready, 1: random 50%, 2: awready held low

  initial begin
    awready = 1'b1;
    wready  = 1'b1;
    bvalid  = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (stall_mode)
        1: begin
          awready = 1'($urandom_range(0, 1));
          wready  = 1'($urandom_range(0, 1));
          bvalid  = 1'($urandom_range(0, 1));
        end
        2: begin awready = 1'b0; wready = 1'b1; bvalid = 1'b1; end
        default: begin awready = 1'b1; wready = 1'b1; bvalid = 1'b1; end
      endcase
    end
  end

  // ---------------- scoreboard / monitor ----------------
  burst_t              exp_q[$];      // written by the main sequence only
  logic [AW+7:0]       aw_log[$];     // written by the monitor only
  int                  clr_req = 0;
  int                  clr_ack = 0;
  int                  rd_idx = 0;
  int                  beat = 0;
  int                  b_count = 0;
  int                  done_pulses = 0;
  burst_t              cur;
  logic                aw_hold = 1'b0, w_hold = 1'b0;
  logic [AW-1:0]       h_addr;
  logic [7:0]          h_len;
  logic [DW-1:0]       h_data;
  logic                h_last;

  initial begin
    forever begin
      @(negedge clk);
      if (clr_req != clr_ack) begin
        rd_idx = 0; beat = 0; b_count = 0; done_pulses = 0;
        aw_hold = 1'b0; w_hold = 1'b0;
        aw_log.delete();
        clr_ack = clr_req;
      end else if (!rst) begin
        if (aw_hold) begin
          check("aw_stall_valid", awvalid, 1'b1);
          check("aw_stall_addr", awaddr, h_addr);
          check("aw_stall_len", awlen, h_len);
        end
        if (w_hold) begin
          check("w_stall_valid", wvalid, 1'b1);
          check("w_stall_data", wdata, h_data);
          check("w_stall_last", wlast, h_last);
        end
        if (awvalid && awready) begin
          if (rd_idx < exp_q.size()) begin
            cur = exp_q[rd_idx];
            rd_idx++;
            check("aw_addr", awaddr, cur.addr);
            check("aw_len", awlen, cur.len);
            check("aw_burst", awburst, 2'b01);
          end else begin
            n_tests++;
            n_fail++;
            $display("FAIL aw_unexpected: got burst at 0x%0h, expected none", awaddr);
          end
          aw_log.push_back({awaddr, awlen});
          beat = 0;
        end
        if (wvalid && wready) begin
          check("w_data", wdata, cur.data[beat]);
          check("w_last", wlast, beat == int'(cur.len));
          beat++;
        end
        if (bvalid && bready) b_count++;
        if (map_done) done_pulses++;
        aw_hold = awvalid && !awready;
        h_addr  = awaddr;
        h_len   = awlen;
        w_hold  = wvalid && !wready;
        h_data  = wdata;
        h_last  = wlast;
      end
    end
  end

  // ---------------- model and helpers ----------------
  int            m_tx = 0, m_ty = 0;
  logic [AW-1:0] m_base = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic tile_t rand_tile();
    tile_t t;
    for (int rr = 0; rr < POY; rr++)
      for (int cc = 0; cc < POX; cc++)
        t[rr][cc] = $urandom;
    return t;
  endfunction

  // Queue the expected bursts of a tile at the model position, then advance.
  task automatic push_tile(input tile_t t);
    int     cols, rows;
    burst_t b;
    cols = OW - m_tx * POX;
    if (cols > POX) cols = POX;
    rows = OH - m_ty * POY;
    if (rows > POY) rows = POY;
    for (int rr = 0; rr < rows; rr++) begin
      b.addr = m_base + AW'(((m_ty * POY + rr) * OW + m_tx * POX) * (DW / 8));
      b.len  = 8'(cols - 1);
      b.data = t[rr];
      exp_q.push_back(b);
    end
    m_tx++;
    if (m_tx == TX) begin
      m_tx = 0;
      m_ty++;
      if (m_ty == TY) m_ty = 0;
    end
  endtask

  task automatic send_tile(input tile_t t);
    result       = t;
    result_valid = 1'b1;
    tick();
    result_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (b_count < exp_q.size() && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_responses"}, 64'(b_count), 64'(exp_q.size()));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    clr_req++;
    tick();
    tick();
    rst  = 1'b0;
    m_tx = 0;
    m_ty = 0;
  endtask

  task automatic set_base(input logic [AW-1:0] a);
    init_addr    = a;
    init_addr_en = 1'b1;
    tick();
    init_addr_en = 1'b0;
    m_base       = a;
  endtask

  task automatic feed_one();
    tile_t t;
    t = rand_tile();
    push_tile(t);
    send_tile(t);
    wait_drain("feed", 400);
  endtask

  // ---------------- tile position table ----------------
  vec_t vec[6];

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    tile_t t1, t2, t3;
    int    nb0, tidx;

    vec[0] = '{0,   32'h1000_0000, 8'd14, 3};  // (0,0)
    vec[1] = '{1,   32'h1000_003C, 8'd14, 3};  // (1,0)
    vec[2] = '{7,   32'h1000_01A4, 8'd6,  3};  // right edge, 7 columns
    vec[3] = '{8,   32'h1000_0540, 8'd14, 3};  // (0,1), row 3
    vec[4] = '{296, 32'h1000_C240, 8'd14, 1};  // (0,37), row 111 only
    vec[5] = '{303, 32'h1000_C3E4, 8'd6,  1};  // last tile, 7 cols x 1 row

    rst          = 1'b1;
    result       = '0;
    result_valid = 1'b0;
    init_addr    = '0;
    init_addr_en = 1'b0;

    // ---- reset state ----
    do_reset();
    @(negedge clk);
    check("rst_awvalid", awvalid, 1'b0);
    check("rst_awaddr", awaddr, 32'h0);
    check("rst_awlen", awlen, 8'h0);
    check("rst_awburst", awburst, 2'b01);
    check("rst_wvalid", wvalid, 1'b0);
    check("rst_wdata", wdata, 32'h0);
    check("rst_wlast", wlast, 1'b0);
    check("rst_bready", bready, 1'b0);
    check("rst_map_done", map_done, 1'b0);
    check("rst_overflow", overflow, 1'b0);

    // ---- single tile at (0,0), always ready, first-AW latency ----
    set_base(BASE);
    t1 = rand_tile();
    push_tile(t1);
    send_tile(t1);
    @(negedge clk);
    check("lat_no_aw_yet", awvalid, 1'b0);
    @(negedge clk);
    check("lat_aw_next", awvalid, 1'b1);
    check("lat_aw_addr", awaddr, 32'h1000_0000);
    wait_drain("tile00", 200);
    check("tile00_row_addrs", {aw_log[0][39:8], aw_log[1][39:8], aw_log[2][39:8]} == {32'h1000_0000, 32'h1000_01C0, 32'h1000_0380}, 1'b1);

    // ---- random stalls, two back-to-back tiles ----
    stall_mode = 1;
    t1 = rand_tile();
    t2 = rand_tile();
    push_tile(t1);
    push_tile(t2);
    result       = t1;
    result_valid = 1'b1;
    tick();
    result       = t2;
    tick();
    result_valid = 1'b0;
    wait_drain("stall", 3000);
    check("stall_overflow", overflow, 1'b0);
    stall_mode = 0;
    tick();

    // ---- overflow: three tiles while AW is blocked ----
    do_reset();
    set_base(BASE);
    stall_mode = 2;
    tick();
    t1 = rand_tile();
    t2 = rand_tile();
    t3 = rand_tile();
    push_tile(t1);
    push_tile(t2);
    result       = t1;
    result_valid = 1'b1;
    tick();
    result = t2;
    tick();
    result = t3;
    tick();
    result_valid = 1'b0;
    // Base change while busy must be ignored.
    init_addr    = 32'h2000_0000;
    init_addr_en = 1'b1;
    tick();
    init_addr_en = 1'b0;
    @(negedge clk);
    check("ovf_set", overflow, 1'b1);
    repeat (4) @(negedge clk);
    check("ovf_sticky_blocked", overflow, 1'b1);
    check("ovf_aw_waiting", awvalid, 1'b1);
    check("ovf_aw_addr", awaddr, 32'h1000_0000);
    stall_mode = 0;
    wait_drain("ovf", 300);
    check("ovf_bursts", 64'(aw_log.size()), 64'd6);
    check("ovf_sticky_after", overflow, 1'b1);

    // ---- reset in the middle of a burst ----
    t1 = rand_tile();
    push_tile(t1);
    send_tile(t1);
    begin
      int n = 0;
      while (!wvalid && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    check("mid_wvalid_seen", wvalid, 1'b1);
    rst = 1'b1;
    exp_q.delete();
    clr_req++;
    @(negedge clk);
    check("mid_rst_wvalid", wvalid, 1'b0);
    check("mid_rst_awvalid", awvalid, 1'b0);
    check("mid_rst_overflow", overflow, 1'b0);
    tick();
    rst  = 1'b0;
    m_tx = 0;
    m_ty = 0;

    // ---- full map with table-checked positions ----
    set_base(BASE);
    tidx = 0;
    for (int v = 0; v < 6; v++) begin
      while (tidx < vec[v].idx) begin
        feed_one();
        tidx++;
      end
      if (tidx == TX * TY - 1) check("map_no_early_done", 64'(done_pulses), 64'd0);
      nb0 = aw_log.size();
      feed_one();
      tidx++;
      check($sformatf("vec%0d_addr", v), aw_log[nb0][39:8], vec[v].addr0);
      check($sformatf("vec%0d_len", v), aw_log[nb0][7:0], vec[v].len);
      check($sformatf("vec%0d_bursts", v), 64'(aw_log.size() - nb0), 64'(vec[v].nbursts));
    end
    tick();
    tick();
    check("map_total_bursts", 64'(aw_log.size()), 64'd896);
    check("map_done_once", 64'(done_pulses), 64'd1);
    check("map_no_overflow", overflow, 1'b0);

    // Tile position must be back at (0,0) for the next map.
    nb0 = aw_log.size();
    feed_one();
    check("map_wrap_addr", aw_log[nb0][39:8], 32'h1000_0000);
    check("map_wrap_bursts", 64'(aw_log.size() - nb0), 64'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/out_tile_writer.md
Name: out_tile_writer

Overview:
- Downstream neighbour of the datapath. Captures each POY x POX result tile from the depthwise PE array into a two-bank ping-pong buffer.
- Drains each tile row-by-row to DRAM over an AXI-style write channel: one INCR burst per output row segment.
- Tracks tile position in the output feature map and clips partial tiles at the right and bottom edges.

Parameters:
- DW, 32, data/beat width in bits; byte stride per pixel = DW/8.
- AW, 32, DRAM address width.
- POX, 15, pixels per tile row; must be <= 256.
- POY, 3, rows per tile.
- OW, 112, output map width in pixels.
- OH, 112, output map height in pixels.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- result  input  DW x [POY][POX]  PE results, one full tile per valid.
- result_valid  input  1  tile present this cycle; caller ties PE element [0][0].
- init_addr  input  AW  output map byte base address.
- init_addr_en  input  1  latch base and clear tile position.
- awaddr  output  AW  burst start byte address.
- awlen  output  8  beats-1.
- awburst  output  2  constant 2'b01 (INCR).
- awvalid  output  1  address valid.
- awready  input  1  address accepted.
- wdata  output  DW  write beat.
- wvalid  output  1  beat valid.
- wready  input  1  beat accepted.
- wlast  output  1  final beat of burst.
- bvalid  input  1  write response.
- bready  output  1  response accept.
- map_done  output  1  one-cycle pulse after the last tile's final B response.
- overflow  output  1  sticky: a tile arrived with both banks full.

Behaviour:
- Reset (sync, rst=1 at posedge): all outputs 0, count=0, pointers=0, tile_x=tile_y=0, base=0, FSM=IDLE. Reset mid-burst drops valid immediately; this is a system-level reset.
- init_addr_en: latches init_addr into base and zeroes tile_x/tile_y. Accepted only when FSM=IDLE and count=0; otherwise ignored.
- Capture:
  - result_valid with count<2 writes the tile into bank wr_ptr, toggles wr_ptr, count+1.
  - result_valid with count==2 drops the tile and sets overflow (cleared only by rst).
  - Capture and bank release in the same cycle leave count unchanged.
- Edge clipping:
  - cols = min(POX, OW - tile_x*POX).
  - rows = min(POY, OH - tile_y*POY).
  - Defaults give 8 x-tiles (last has cols=7) and 38 y-tiles (last has rows=1).
- FSM:
  - IDLE: count>0 -> ADDR, with r=0. Earliest awvalid is 1 cycle after the capture edge.
  - ADDR: awvalid=1. awaddr = base + ((tile_y*POY + r)*OW + tile_x*POX)*(DW/8). awlen = cols-1. Address held stable until awready. On handshake -> DATA, c=0.
  - DATA: wvalid=1, wdata = bank[rd_ptr][r][c], wlast = (c==cols-1). Beat held stable until wready. c++ per handshake. On the last handshake -> RESP.
  - RESP: bready=1. On bvalid:
    - if r<rows-1: r++, go to ADDR.
    - else: release bank (rd_ptr toggles, count-1) and advance tile_x. On wrap, tile_x=0 and tile_y++.
    - If the finished tile was the last of the map: pulse map_done, zero tile_x/tile_y, go to IDLE.
    - Otherwise go to ADDR if count-after>0, else IDLE.
- Outstanding transactions: at most one; the next AW is issued only after B of the previous one.
- Rows beyond OH within a tile are never written. Columns beyond OW are never written.
- Address arithmetic is unsigned, computed at AW width, truncated to AW; no wrap check.

Decomposition:
- Package out_tile_pkg holds:
  - enum state_t {IDLE, ADDR, DATA, RESP};
  - BURST_INCR=2'b01;
  - localparams TILES_X=ceil(OW/POX), TILES_Y=ceil(OH/POY), BYTES=DW/8;
  - clog2-derived counter widths.
- Sub-module tile_pingpong: two-bank POY x POX storage with wr_ptr/rd_ptr/count, full/empty flags and read mux by (r,c).
- FSM and address generation stay in out_tile_writer.

Test Plan:
- base=0x1000_0000, one tile at (0,0), awready/wready/bvalid always 1 -> three bursts:
  - 0x1000_0000, 0x1000_01C0, 0x1000_0380;
  - each awlen=14, 15 beats, wlast on beat 15;
  - row data matches result[r][0..14].
- Tile at tile_x=7 -> awaddr base+0x1A4, awlen=6, 7 beats; result[.][7..14] never written.
- Tile at tile_y=37 -> single burst at base+0xC240 (row 111); rows 1-2 skipped; bank released after one B.
- Random awready/wready/bvalid stalls (50% duty) -> awaddr/wdata/wlast stable while valid & !ready; beat order preserved.
- Three result_valid pulses on consecutive cycles with awready held 0 -> first two captured, third dropped, overflow=1 sticky.
- Full map: 304 tiles fed at spacing >=46 cycles -> exactly 8*(37*3+1)=896 bursts; map_done pulses once after the final B; tile counters return to 0.
